pla_vec_driver: RTL and testbench
=================================

PLA_VEC_DRIVER -- requirements
Module: pla_vec_driver

Interface
REQ-001 Parameter SIG_W, default 16: width of the response signature register; legal values are 16 only in this revision.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port start, input, 1: run request, sampled in IDLE only.
REQ-005 Port mode, input, 1: vector source select; 0 = exhaustive up-counter, 1 = LFSR; sampled with start.
REQ-006 Port seed, input, 7: first vector; sampled with start.
REQ-007 Port num_vec, input, 8: vectors per run; 0 encodes 256; sampled with start.
REQ-008 Port vec_out, output, 7: registered stimulus to the PLA under test; bit i drives input vi.
REQ-009 Port resp_in, input, 3: combinational PLA response; bit i is output v7.i.
REQ-010 Port busy, output, 1: high while in RUN.
REQ-011 Port done, output, 1: one-cycle pulse on run completion.
REQ-012 Port signature, output, SIG_W: MISR contents.
REQ-013 Port toggle_cnt, output, 16: stimulus bit-toggle count (power proxy); present only per REQ-027.

Function
REQ-014 FSM states are IDLE, RUN and DONE; the reset state is IDLE.
REQ-015 In IDLE with start=1, the block SHALL latch mode/num_vec, clear signature and toggle_cnt to 0, load vec_out with the first vector, and enter RUN.
REQ-016 First vector: seed when mode=0; seed when mode=1 and seed!=0; 7'h01 when mode=1 and seed=0.
REQ-017 Every RUN cycle absorbs exactly one response: signature <= {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ {13'b0, resp_in}.
REQ-018 Next vector, mode=0: vec_out+1 modulo 128 (127 wraps to 0).
REQ-019 Next vector, mode=1: Fibonacci LFSR x^7+x^6+1; vec_out <= {vec_out[5:0], vec_out[6]^vec_out[5]}.
REQ-020 On the RUN cycle absorbing vector N (N = num_vec, or 256 when num_vec=0), the FSM SHALL go to DONE with vec_out held; otherwise vec_out advances to the next vector.
REQ-021 A run of N vectors occupies exactly N RUN cycles; busy=1 for exactly those N cycles.
REQ-022 DONE lasts one cycle with done=1 and busy=0, then the FSM returns to IDLE.
REQ-023 start is ignored in RUN and DONE; a new run is accepted no earlier than the first IDLE cycle.
REQ-024 vec_out and signature hold their last values in DONE and IDLE until the next accepted start.

Reset
REQ-025 rst=1 at any clock edge, including mid-run, SHALL force IDLE, vec_out=0, signature=0, toggle_cnt=0, busy=0, done=0; an in-flight run is discarded and done is not pulsed.
REQ-026 rst takes priority over start on the same edge.

Configuration
REQ-027 Macro PLA_VEC_TOGGLE_CNT_EN defined: each vec_out advance within a run adds popcount(old ^ new) to toggle_cnt, saturating at 16'hFFFF; the first vector of a run does not count.
REQ-028 Macro PLA_VEC_TOGGLE_CNT_EN undefined: the toggle_cnt port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-029 mode=0, seed=0, num_vec=128, resp_in held 0 -> vec_out steps 0..127 on consecutive cycles, busy high exactly 128 cycles, done pulse one cycle later, signature=16'h0000.
REQ-030 mode=0, num_vec=2, resp_in held 3'b001 -> signature=16'h0003 at done.
REQ-031 mode=1, seed=0, num_vec=3 -> vec_out sequence 7'h01, 7'h02, 7'h04.
REQ-032 PLA_VEC_TOGGLE_CNT_EN defined, mode=0, seed=0, num_vec=128 -> toggle_cnt=247 at done.
REQ-033 rst asserted on the 10th RUN cycle -> next cycle IDLE, all outputs 0, no done pulse; a start pulse asserted while busy=1 does not restart or extend the run.
REQ-034 num_vec=0, mode=0, seed=7'h7F -> 256 RUN cycles, vec_out wraps 7F->00, done pulses once.

Source files
------------

// File: rtl/pla_vec_driver_if.sv
// pla_vec_driver_if: bundles the run-control and PLA stimulus/response
// signals of pla_vec_driver.
//   start/mode/seed/num_vec : run request and its configuration
//   vec_out / resp_in       : stimulus to and response from the PLA
//   busy/done               : run status
//   signature               : MISR contents
//   toggle_cnt              : stimulus bit-toggle count, present only when
//                             PLA_VEC_TOGGLE_CNT_EN is defined
// Modports: slave = driver side, master = controller/PLA side.
interface pla_vec_driver_if #(
  parameter int unsigned SIG_W = 16
);
  logic             start;
  logic             mode;
  logic [6:0]       seed;
  logic [7:0]       num_vec;
  logic [6:0]       vec_out;
  logic [2:0]       resp_in;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
`ifdef PLA_VEC_TOGGLE_CNT_EN
  logic [15:0]      toggle_cnt;
`endif

  modport slave (
    input  start, mode, seed, num_vec, resp_in,
`ifdef PLA_VEC_TOGGLE_CNT_EN
    output toggle_cnt,
`endif
    output vec_out, busy, done, signature
  );

  modport master (
    output start, mode, seed, num_vec, resp_in,
`ifdef PLA_VEC_TOGGLE_CNT_EN
    input  toggle_cnt,
`endif
    input  vec_out, busy, done, signature
  );
endinterface

// File: rtl/pla_vec_driver.sv
// pla_vec_driver: applies a run of 7-bit stimulus vectors to a PLA
// (exhaustive up-counter or x^7+x^6+1 LFSR) and compresses its 3-bit
// response into a 16-bit MISR signature.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : pla_vec_driver_if.slave (start, mode, seed, num_vec, resp_in in;
//         vec_out, busy, done, signature, [toggle_cnt] out)
// Optional feature: define PLA_VEC_TOGGLE_CNT_EN to add the saturating
// stimulus bit-toggle counter on bus.toggle_cnt.
module pla_vec_driver #(
  parameter int unsigned SIG_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  pla_vec_driver_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [8:0]       r_left;   // vectors still to absorb, including current
  logic [6:0]       r_vec;
  logic [SIG_W-1:0] r_sig;
  logic             r_busy;
  logic             r_done;

  logic [6:0]       w_first_vec;
  logic [6:0]       w_next_vec;
  logic [SIG_W-1:0] w_sig_next;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  assign w_first_vec = (bus.mode && (bus.seed == '0)) ? 7'h01 : bus.seed;

  assign w_next_vec = r_mode ? {r_vec[5:0], r_vec[6] ^ r_vec[5]}
                             : r_vec + 7'd1;

  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? SIG_W'(16'h1021) : '0)
                    ^ SIG_W'(bus.resp_in);

`ifdef PLA_VEC_TOGGLE_CNT_EN
  logic [15:0] r_tog;
  logic [6:0]  w_diff;
  logic [2:0]  w_pop;
  logic [16:0] w_tog_sum;
  logic [15:0] w_tog_next;

  always_comb begin
    w_diff = r_vec ^ w_next_vec;
    w_pop  = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      w_pop = w_pop + {2'b00, w_diff[i]};
    end
    w_tog_sum  = {1'b0, r_tog} + 17'(w_pop);
    w_tog_next = w_tog_sum[16] ? '1 : w_tog_sum[15:0];
  end

  assign bus.toggle_cnt = r_tog;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_left  <= '0;
      r_vec   <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PLA_VEC_TOGGLE_CNT_EN
      r_tog   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_left  <= (bus.num_vec == '0) ? 9'd256 : {1'b0, bus.num_vec};
            r_vec   <= w_first_vec;
            r_sig   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef PLA_VEC_TOGGLE_CNT_EN
            r_tog   <= '0;
`endif
          end
        end
        RUN: begin
          r_sig <= w_sig_next;
          if (r_left == 9'd1) begin
            // Last vector absorbed: hold vec_out, signal completion.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_vec  <= w_next_vec;
            r_left <= r_left - 9'd1;
`ifdef PLA_VEC_TOGGLE_CNT_EN
            r_tog  <= w_tog_next;
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out   = r_vec;
  assign bus.signature = r_sig;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_pla_vec_driver.sv
// tb_pla_vec_driver: directed scoreboard bench for pla_vec_driver. The
// expected vector stream of each run is queued when the run is started and
// popped on every RUN cycle; signature and toggle count come from a
// bench-side reference model of the MISR and LFSR/counter.
module tb_pla_vec_driver;

  logic clk;
  logic rst;

  pla_vec_driver_if #(.SIG_W(16)) bus_if ();

  pla_vec_driver #(.SIG_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int unsigned n_checks;
  int unsigned n_errors;
  logic [6:0]  exp_q[$];

  // PLA response: either a constant or a small PLA function of the stimulus.
  logic       resp_hold;
  logic [2:0] resp_const;

  function automatic logic [2:0] pla_fn(input logic [6:0] v);
    return {v[0] & v[1], v[2] | v[3], v[4] ^ v[5] ^ v[6]};
  endfunction

  function automatic logic [2:0] resp_model(input logic [6:0] v);
    return resp_hold ? resp_const : pla_fn(v);
  endfunction

  assign bus_if.resp_in = resp_model(bus_if.vec_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [2:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, r};
  endfunction

  function automatic int unsigned popcnt7(input logic [6:0] x);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 7; i++) c += x[i];
    return c;
  endfunction

  // abort_at: RUN cycle (1-based) on which rst is raised, 0 = none.
  // glitch_at: RUN cycle (1-based) during which start is pulsed, 0 = none.
  task automatic run_vec(input logic m, input logic [6:0] s, input logic [7:0] n,
                         input int unsigned abort_at, input int unsigned glitch_at,
                         input string tag);
    int unsigned nv;
    int unsigned tog;
    logic [6:0]  v, nx, last, ev;
    logic [15:0] sig;
    nv   = (n == 8'd0) ? 256 : int'(n);
    v    = (m && (s == 7'd0)) ? 7'h01 : s;
    sig  = '0;
    tog  = 0;
    last = v;
    exp_q.delete();
    for (int unsigned i = 0; i < nv; i++) begin
      exp_q.push_back(v);
      sig  = sig_step(sig, resp_model(v));
      last = v;
      if (i != nv - 1) begin
        nx  = m ? {v[5:0], v[6] ^ v[5]} : 7'(v + 7'd1);
        tog = tog + popcnt7(v ^ nx);
        if (tog > 16'hFFFF) tog = 16'hFFFF;
        v = nx;
      end
    end

    @(negedge clk);
    bus_if.mode    = m;
    bus_if.seed    = s;
    bus_if.num_vec = n;
    bus_if.start   = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;

    for (int unsigned i = 1; i <= nv; i++) begin
      @(negedge clk);
      bus_if.start = (glitch_at == i);
      ev = exp_q.pop_front();
      chk({tag, " vec"},  32'(bus_if.vec_out), 32'(ev));
      chk({tag, " busy"}, 32'(bus_if.busy), 32'd1);
      chk({tag, " done"}, 32'(bus_if.done), 32'd0);
      if (abort_at == i) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.start = 1'b0;
        chk({tag, " rst vec"},  32'(bus_if.vec_out), 32'd0);
        chk({tag, " rst sig"},  32'(bus_if.signature), 32'd0);
        chk({tag, " rst busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, " rst done"}, 32'(bus_if.done), 32'd0);
`ifdef PLA_VEC_TOGGLE_CNT_EN
        chk({tag, " rst tog"},  32'(bus_if.toggle_cnt), 32'd0);
`endif
        repeat (3) begin
          @(negedge clk);
          chk({tag, " no done after rst"}, 32'(bus_if.done), 32'd0);
          chk({tag, " no busy after rst"}, 32'(bus_if.busy), 32'd0);
        end
        return;
      end
    end

    @(negedge clk);
    bus_if.start = 1'b0;
    chk({tag, " done pulse"}, 32'(bus_if.done), 32'd1);
    chk({tag, " done busy"},  32'(bus_if.busy), 32'd0);
    chk({tag, " signature"},  32'(bus_if.signature), 32'(sig));
    chk({tag, " vec held"},   32'(bus_if.vec_out), 32'(last));
`ifdef PLA_VEC_TOGGLE_CNT_EN
    chk({tag, " toggle_cnt"}, 32'(bus_if.toggle_cnt), 32'(tog));
`endif
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(bus_if.done), 32'd0);
    chk({tag, " idle busy"},      32'(bus_if.busy), 32'd0);
    @(negedge clk);
    chk({tag, " idle vec hold"},  32'(bus_if.vec_out), 32'(last));
    chk({tag, " idle sig hold"},  32'(bus_if.signature), 32'(sig));
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    resp_hold      = 1'b1;
    resp_const     = 3'b000;
    rst            = 1'b1;
    bus_if.start   = 1'b1;   // must lose to rst
    bus_if.mode    = 1'b0;
    bus_if.seed    = 7'h00;
    bus_if.num_vec = 8'd4;

    repeat (3) @(negedge clk);
    chk("reset vec",  32'(bus_if.vec_out), 32'd0);
    chk("reset sig",  32'(bus_if.signature), 32'd0);
    chk("reset busy", 32'(bus_if.busy), 32'd0);
    chk("reset done", 32'(bus_if.done), 32'd0);
`ifdef PLA_VEC_TOGGLE_CNT_EN
    chk("reset tog",  32'(bus_if.toggle_cnt), 32'd0);
`endif
    bus_if.start = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    chk("idle after reset busy", 32'(bus_if.busy), 32'd0);

    // Exhaustive 0..127 with zero response.
    run_vec(1'b0, 7'h00, 8'd128, 0, 0, "cnt128");

    // Constant response 3'b001 over two vectors.
    resp_const = 3'b001;
    run_vec(1'b0, 7'h05, 8'd2, 0, 0, "sig2");

    // PLA-driven response from here on.
    resp_hold = 1'b0;
    run_vec(1'b1, 7'h00, 8'd3, 0, 0, "lfsr_seed0");
    run_vec(1'b1, 7'h55, 8'd20, 0, 0, "lfsr55");
    run_vec(1'b0, 7'h7F, 8'd0, 0, 0, "wrap256");

    // Reset on 10th RUN cycle, with a start pulse during the run.
    run_vec(1'b0, 7'h10, 8'd50, 10, 3, "abort");

    // Start pulses while busy must neither restart nor extend the run.
    run_vec(1'b1, 7'h03, 8'd8, 0, 4, "glitch_mid");
    run_vec(1'b0, 7'h20, 8'd5, 0, 5, "glitch_last");

    // Single-vector run.
    run_vec(1'b0, 7'h7E, 8'd1, 0, 0, "n1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
